ts_rd_scheduler: RTL and testbench
==================================

TS_RD_SCHEDULER -- requirements
Module: ts_rd_scheduler

Interface
REQ-001 Parameter N_CH, default 4, number of TS buffer channels; fixed at 4 in this release.
REQ-002 Parameter PKT_LEN, default 188, TS packet length in bytes.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cfg_en  input  1  scheduler enable, level.
REQ-006 cfg_rate_step  input  16  byte-rate NCO step; strobe rate = clk * step / 65536.
REQ-007 ch_frame_rdy  input  4  per-channel flag: buffer holds >= one full packet.
REQ-008 ch_rd_en  output  4  per-channel byte read enable, one-hot or zero.
REQ-009 ch_sel  output  2  channel currently granted; drives the data select in front of the idle mux.
REQ-010 ts_rd_req  output  1  one-cycle byte read strobe toward the idle/data mux.
REQ-011 ts_rd_sync  output  1  one-cycle strobe marking byte 0 (0x47 position) of each packet.
REQ-012 tsbuf_has_frame  output  1  current packet is buffer data (1) or idle packet (0).
REQ-013 pkt_done  output  1  one-cycle pulse on the last byte strobe of each packet.
REQ-014 data_pkt_cnt  output  16  count of data packets started, wraps at 65535 -> 0.
REQ-015 idle_pkt_cnt  output  16  count of idle packets started, wraps at 65535 -> 0.

Function
REQ-016 NCO: 16-bit accumulator acc adds cfg_rate_step every clk while state != IDLE; a carry out sets internal strobe for that cycle.
REQ-017 cfg_rate_step = 0 produces no strobes; the scheduler stalls in place, all counters held.
REQ-018 States: IDLE, ARB, SEND; encoding 2-bit binary.
REQ-019 IDLE: acc cleared, byte_cnt = 0; go to ARB when cfg_en = 1.
REQ-020 ARB: on first strobe, round-robin pick among ch_frame_rdy starting at (last_grant+1) mod 4; if a winner, latch ch_sel = winner, tsbuf_has_frame = 1, update last_grant, increment data_pkt_cnt; else tsbuf_has_frame = 0, ch_sel unchanged, increment idle_pkt_cnt; byte_cnt -> 1; go to SEND.
REQ-021 The ARB strobe cycle asserts ts_rd_req and ts_rd_sync, registered: both high exactly the cycle after the carry.
REQ-022 SEND: each strobe asserts ts_rd_req (registered, one cycle), byte_cnt increments; on strobe with byte_cnt = PKT_LEN-1 assert pkt_done, byte_cnt -> 0, go to ARB if cfg_en = 1 else IDLE.
REQ-023 ch_rd_en[ch_sel] equals ts_rd_req when tsbuf_has_frame = 1; all ch_rd_en bits 0 otherwise.
REQ-024 tsbuf_has_frame and ch_sel change only in the cycle ts_rd_sync is asserted; constant for the whole packet.
REQ-025 ch_frame_rdy changes mid-packet are ignored; sampled only at ARB strobe.
REQ-026 cfg_en deassert mid-packet: current packet completes all PKT_LEN strobes, then IDLE; no truncated packets.
REQ-027 pkt_done on same strobe as cfg_en reassert: next state ARB, no IDLE gap.
REQ-028 Exactly PKT_LEN ts_rd_req pulses between consecutive ts_rd_sync pulses; ts_rd_sync coincides with a ts_rd_req pulse.
REQ-029 Round-robin pointer last_grant unchanged by idle packets.

Reset
REQ-030 rst asserted (any cycle, incl. mid-packet): state IDLE, acc 0, byte_cnt 0, last_grant 3 (so channel 0 has first priority).
REQ-031 Output reset values: ch_rd_en 0, ch_sel 0, ts_rd_req 0, ts_rd_sync 0, tsbuf_has_frame 0, pkt_done 0, data_pkt_cnt 0, idle_pkt_cnt 0.
REQ-032 First strobe after rst release with cfg_en = 1 starts a packet at byte 0.

Structure
REQ-033 Shared package ts_sched_pkg holds TS_PKT_LEN = 188, N_CH = 4, state encoding constants.
REQ-034 Round-robin selection implemented in sub-module rr_arbiter4 (req[3:0], last_grant[1:0] -> valid, grant[1:0]), purely combinational.
REQ-035 All module outputs registered.

Verification
REQ-036 rst release, cfg_en = 1, step = 0x8000, ch_frame_rdy = 0 -> ts_rd_req every 2 clk, ts_rd_sync every 376 clk, tsbuf_has_frame = 0, idle_pkt_cnt increments per packet.
REQ-037 ch_frame_rdy = 4'b1111, step = 0xFFFF -> grants 0,1,2,3,0 on successive packets; ch_rd_en one-hot matching ch_sel, 188 pulses each.
REQ-038 ch_frame_rdy = 4'b0100 rising at byte 50 of an idle packet -> current packet stays idle; next packet data on channel 2.
REQ-039 cfg_en dropped at byte 10 -> 178 further ts_rd_req, pkt_done, then IDLE, no strobes.
REQ-040 rst asserted at byte 100 of a data packet -> all outputs 0 next cycle; after release new packet begins with ts_rd_sync, ch_sel = 0 if channel 0 ready.
REQ-041 data_pkt_cnt preloaded via 65535 packets (or forced) -> wraps to 0 on next data packet.

Source files
------------

// File: rtl/ts_sched_pkg.sv
// Shared constants and types for the TS read scheduler.
//   TS_PKT_LEN : transport-stream packet length in bytes
//   N_CH       : number of TS buffer channels
//   RATE_W     : width of the byte-rate NCO step/accumulator
//   CNT_W      : width of the packet counters
//   state_t    : scheduler state encoding (2-bit binary)
package ts_sched_pkg;

  localparam int unsigned TS_PKT_LEN = 188;
  localparam int unsigned N_CH       = 4;
  localparam int unsigned RATE_W     = 16;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_SEND = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way combinational round-robin arbiter.
//   req        : request vector, one bit per channel
//   last_grant : previously granted channel; search starts at last_grant+1
//   valid      : at least one request present
//   grant      : winning channel (last_grant when no request)
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] last_grant,
  output logic       valid,
  output logic [1:0] grant
);

  logic [1:0] w_idx;

  // Scan from lowest to highest priority so the nearest requester wins last.
  always_comb begin
    valid = 1'b0;
    grant = last_grant;
    w_idx = '0;
    for (int i = 4; i >= 1; i--) begin
      w_idx = last_grant + 2'(i);
      if (req[w_idx]) begin
        valid = 1'b1;
        grant = w_idx;
      end
    end
  end

endmodule

// File: rtl/ts_rd_scheduler.sv
// TS read scheduler: an NCO paces byte strobes; each packet of PKT_LEN
// strobes is taken from a round-robin selected ready channel, or is an
// idle packet when no channel holds a full packet.
//   clk, rst         : clock, asynchronous active-high reset
//   cfg_en           : scheduler enable (level)
//   cfg_rate_step    : NCO step, strobe rate = clk * step / 65536
//   ch_frame_rdy     : per-channel "full packet available"
//   ch_rd_en         : per-channel byte read enable (one-hot or zero)
//   ch_sel           : granted channel for the current packet
//   ts_rd_req        : byte read strobe
//   ts_rd_sync       : strobe on byte 0 of each packet
//   tsbuf_has_frame  : current packet is buffer data (1) or idle (0)
//   pkt_done         : strobe on the last byte of each packet
//   data_pkt_cnt     : data packets started (wrapping)
//   idle_pkt_cnt     : idle packets started (wrapping)
module ts_rd_scheduler #(
  parameter int unsigned N_CH    = ts_sched_pkg::N_CH,
  parameter int unsigned PKT_LEN = ts_sched_pkg::TS_PKT_LEN
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_en,
  input  logic [ts_sched_pkg::RATE_W-1:0]  cfg_rate_step,
  input  logic [N_CH-1:0]                  ch_frame_rdy,
  output logic [N_CH-1:0]                  ch_rd_en,
  output logic [1:0]                       ch_sel,
  output logic                             ts_rd_req,
  output logic                             ts_rd_sync,
  output logic                             tsbuf_has_frame,
  output logic                             pkt_done,
  output logic [ts_sched_pkg::CNT_W-1:0]   data_pkt_cnt,
  output logic [ts_sched_pkg::CNT_W-1:0]   idle_pkt_cnt
);

  import ts_sched_pkg::*;

  localparam int unsigned BC_W = $clog2(PKT_LEN);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [RATE_W-1:0] r_acc;
  logic [RATE_W-1:0] w_acc_nxt;
  logic [RATE_W:0]   w_acc_sum;
  logic              w_strobe;
  logic [BC_W-1:0]   r_byte_cnt;
  logic [BC_W-1:0]   w_byte_cnt_nxt;
  logic              w_last_byte;
  logic [1:0]        r_last_grant;
  logic [1:0]        w_last_grant_nxt;
  logic              w_arb_valid;
  logic [1:0]        w_arb_grant;

  logic [N_CH-1:0]   w_rd_en_nxt;
  logic [1:0]        w_sel_nxt;
  logic              w_req_nxt;
  logic              w_sync_nxt;
  logic              w_has_nxt;
  logic              w_done_nxt;
  logic [CNT_W-1:0]  w_data_cnt_nxt;
  logic [CNT_W-1:0]  w_idle_cnt_nxt;

  // NCO carry is the byte strobe; accumulator only runs outside IDLE.
  assign w_acc_sum   = {1'b0, r_acc} + {1'b0, cfg_rate_step};
  assign w_strobe    = (r_state != ST_IDLE) && w_acc_sum[RATE_W];
  assign w_last_byte = (r_byte_cnt == BC_W'(PKT_LEN - 1));

  rr_arbiter4 u_arb (
    .req        (ch_frame_rdy),
    .last_grant (r_last_grant),
    .valid      (w_arb_valid),
    .grant      (w_arb_grant)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (cfg_en) w_state_nxt = ST_ARB;
      ST_ARB:  if (w_strobe) w_state_nxt = ST_SEND;
      ST_SEND: if (w_strobe && w_last_byte) w_state_nxt = cfg_en ? ST_ARB : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    w_acc_nxt        = (r_state == ST_IDLE) ? '0 : w_acc_sum[RATE_W-1:0];
    w_byte_cnt_nxt   = r_byte_cnt;
    w_last_grant_nxt = r_last_grant;
    w_sel_nxt        = ch_sel;
    w_has_nxt        = tsbuf_has_frame;
    w_req_nxt        = 1'b0;
    w_sync_nxt       = 1'b0;
    w_done_nxt       = 1'b0;
    w_data_cnt_nxt   = data_pkt_cnt;
    w_idle_cnt_nxt   = idle_pkt_cnt;
    case (r_state)
      ST_IDLE: w_byte_cnt_nxt = '0;
      ST_ARB: begin
        if (w_strobe) begin
          w_req_nxt      = 1'b1;
          w_sync_nxt     = 1'b1;
          w_byte_cnt_nxt = BC_W'(1);
          if (w_arb_valid) begin
            w_sel_nxt        = w_arb_grant;
            w_has_nxt        = 1'b1;
            w_last_grant_nxt = w_arb_grant;
            w_data_cnt_nxt   = data_pkt_cnt + CNT_W'(1);
          end else begin
            w_has_nxt      = 1'b0;
            w_idle_cnt_nxt = idle_pkt_cnt + CNT_W'(1);
          end
        end
      end
      ST_SEND: begin
        if (w_strobe) begin
          w_req_nxt = 1'b1;
          if (w_last_byte) begin
            w_done_nxt     = 1'b1;
            w_byte_cnt_nxt = '0;
          end else begin
            w_byte_cnt_nxt = r_byte_cnt + BC_W'(1);
          end
        end
      end
      default: w_byte_cnt_nxt = '0;
    endcase
    w_rd_en_nxt = (w_req_nxt && w_has_nxt) ? (N_CH'(1) << w_sel_nxt) : '0;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc           <= '0;
      r_byte_cnt      <= '0;
      r_last_grant    <= 2'd3;
      ch_rd_en        <= '0;
      ch_sel          <= '0;
      ts_rd_req       <= 1'b0;
      ts_rd_sync      <= 1'b0;
      tsbuf_has_frame <= 1'b0;
      pkt_done        <= 1'b0;
      data_pkt_cnt    <= '0;
      idle_pkt_cnt    <= '0;
    end else begin
      r_acc           <= w_acc_nxt;
      r_byte_cnt      <= w_byte_cnt_nxt;
      r_last_grant    <= w_last_grant_nxt;
      ch_rd_en        <= w_rd_en_nxt;
      ch_sel          <= w_sel_nxt;
      ts_rd_req       <= w_req_nxt;
      ts_rd_sync      <= w_sync_nxt;
      tsbuf_has_frame <= w_has_nxt;
      pkt_done        <= w_done_nxt;
      data_pkt_cnt    <= w_data_cnt_nxt;
      idle_pkt_cnt    <= w_idle_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ts_rd_scheduler.sv
// Bench for ts_rd_scheduler: random stimulus, packet-level reference model,
// scoreboard queue of expected byte strobes, negedge monitor.
module tb_ts_rd_scheduler;

  localparam int PKT = 188;

  logic        clk;
  logic        rst;
  logic        cfg_en;
  logic [15:0] cfg_rate_step;
  logic [3:0]  ch_frame_rdy;
  logic [3:0]  ch_rd_en;
  logic [1:0]  ch_sel;
  logic        ts_rd_req;
  logic        ts_rd_sync;
  logic        tsbuf_has_frame;
  logic        pkt_done;
  logic [15:0] data_pkt_cnt;
  logic [15:0] idle_pkt_cnt;

  ts_rd_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_en          (cfg_en),
    .cfg_rate_step   (cfg_rate_step),
    .ch_frame_rdy    (ch_frame_rdy),
    .ch_rd_en        (ch_rd_en),
    .ch_sel          (ch_sel),
    .ts_rd_req       (ts_rd_req),
    .ts_rd_sync      (ts_rd_sync),
    .tsbuf_has_frame (tsbuf_has_frame),
    .pkt_done        (pkt_done),
    .data_pkt_cnt    (data_pkt_cnt),
    .idle_pkt_cnt    (idle_pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sync;
    logic       done;
    logic       has;
    logic [1:0] sel;
  } exp_t;

  exp_t q[$];

  // Reference model state (written only by the model process).
  bit              m_run;
  longint unsigned m_total;
  int              m_byte;
  int              m_lg;
  logic            vis_req;
  logic [1:0]      vis_sel;
  logic            vis_has;
  logic [15:0]     vis_data;
  logic [15:0]     vis_idle;

  // Bench control (written only by the stimulus process).
  bit force_active;
  bit done_flag;
  int tmo;

  int n_vec;
  int n_bad;

  // Packet-level model: strobe whenever floor(sum_of_steps / 65536) advances.
  always @(posedge clk or posedge rst) begin
    longint unsigned nt;
    exp_t            rec;
    int              c;
    if (rst) begin
      m_run    = 0;
      m_total  = 0;
      m_byte   = 0;
      m_lg     = 3;
      vis_req  = 1'b0;
      vis_sel  = 2'd0;
      vis_has  = 1'b0;
      vis_data = 16'd0;
      vis_idle = 16'd0;
      q.delete();
    end else begin
      vis_req = 1'b0;
      if (!m_run) begin
        m_total = 0;
        m_byte  = 0;
        if (cfg_en) m_run = 1;
      end else begin
        nt = m_total + longint'(cfg_rate_step);
        if ((nt >> 16) != (m_total >> 16)) begin
          vis_req = 1'b1;
          if (m_byte == 0) begin
            c = -1;
            for (int d = 1; d <= 4; d++)
              if (c < 0 && ch_frame_rdy[(m_lg + d) % 4]) c = (m_lg + d) % 4;
            if (c >= 0) begin
              vis_has  = 1'b1;
              vis_sel  = 2'(c);
              m_lg     = c;
              vis_data = vis_data + 16'd1;
            end else begin
              vis_has  = 1'b0;
              vis_idle = vis_idle + 16'd1;
            end
          end
          rec.sync = (m_byte == 0);
          rec.done = (m_byte == PKT - 1);
          rec.has  = vis_has;
          rec.sel  = vis_sel;
          q.push_back(rec);
          if (m_byte == PKT - 1) begin
            m_byte = 0;
            if (!cfg_en) m_run = 0;
          end else begin
            m_byte = m_byte + 1;
          end
        end
        m_total = nt;
      end
      if (force_active) vis_data = 16'hFFFE;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t       rec;
    logic [3:0] one;
    logic [3:0] exp_en;
    one = 4'b0001;
    if (done_flag) begin
      n_vec++;
      if (q.size() != 0) begin
        n_bad++;
        $display("FAIL drain: %0d expected strobes never seen, required 0", q.size());
      end
      n_vec++;
      if (tmo != 0) begin
        n_bad += tmo;
        $display("FAIL wait_bound: %0d waits expired, required 0", tmo);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
    end else begin
      n_vec++;
      if (ts_rd_req !== vis_req || ch_sel !== vis_sel || tsbuf_has_frame !== vis_has ||
          idle_pkt_cnt !== vis_idle || (!force_active && data_pkt_cnt !== vis_data)) begin
        n_bad++;
        $display("FAIL state t=%0t: req=%b sel=%0d has=%b data=%0d idle=%0d, required req=%b sel=%0d has=%b data=%0d idle=%0d",
                 $time, ts_rd_req, ch_sel, tsbuf_has_frame, data_pkt_cnt, idle_pkt_cnt,
                 vis_req, vis_sel, vis_has, vis_data, vis_idle);
      end
      if (ts_rd_req === 1'b1) begin
        n_vec++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL byte t=%0t: strobe seen, required no strobe (queue empty)", $time);
        end else begin
          rec    = q.pop_front();
          exp_en = rec.has ? (one << rec.sel) : 4'b0000;
          if (ts_rd_sync !== rec.sync || pkt_done !== rec.done || ch_rd_en !== exp_en) begin
            n_bad++;
            $display("FAIL byte t=%0t: sync=%b done=%b rd_en=%b, required sync=%b done=%b rd_en=%b",
                     $time, ts_rd_sync, pkt_done, ch_rd_en, rec.sync, rec.done, exp_en);
          end
        end
      end else if (ts_rd_sync !== 1'b0 || pkt_done !== 1'b0 || ch_rd_en !== 4'b0000) begin
        n_bad++;
        $display("FAIL quiet t=%0t: sync=%b done=%b rd_en=%b, required 0 0 0000",
                 $time, ts_rd_sync, pkt_done, ch_rd_en);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Wait until the model is about to emit byte b (optionally of a data/idle packet).
  task automatic wait_byte(input int b, input bit chk_has, input logic want_has);
    bit found;
    found = 0;
    for (int i = 0; i < 5000 && !found; i++) begin
      if (m_run && m_byte == b && (!chk_has || vis_has == want_has)) found = 1;
      else tick(1);
    end
    if (!found) tmo++;
  endtask

  task automatic wait_idle();
    bit found;
    found = 0;
    for (int i = 0; i < 8000 && !found; i++) begin
      if (!m_run) found = 1;
      else tick(1);
    end
    if (!found) tmo++;
  endtask

  initial begin
    rst           = 1'b1;
    cfg_en        = 1'b0;
    cfg_rate_step = 16'h0000;
    ch_frame_rdy  = 4'b0000;
    force_active  = 0;
    done_flag     = 0;
    tmo           = 0;
    n_vec         = 0;
    n_bad         = 0;
    tick(3);
    rst = 1'b0;
    tick(3);

    // Idle packets at half rate.
    cfg_rate_step = 16'h8000;
    cfg_en        = 1'b1;
    tick(376 * 3 + 10);

    // All channels ready at near full rate: rotating grants.
    ch_frame_rdy  = 4'b1111;
    cfg_rate_step = 16'hFFFF;
    tick(1200);

    // Channel 2 appears mid idle packet: that packet stays idle.
    ch_frame_rdy = 4'b0000;
    wait_byte(50, 1, 1'b0);
    ch_frame_rdy = 4'b0100;
    tick(600);

    // Enable dropped early in a packet: packet completes, then idle.
    cfg_rate_step = 16'h8000;
    wait_byte(10, 0, 1'b0);
    cfg_en = 1'b0;
    tick(500);

    // Zero step stalls in place.
    cfg_en        = 1'b1;
    cfg_rate_step = 16'h4000;
    tick(100);
    cfg_rate_step = 16'h0000;
    tick(60);
    cfg_rate_step = 16'h4000;
    tick(100);

    // Reset in the middle of a data packet.
    ch_frame_rdy  = 4'b0101;
    cfg_rate_step = 16'hFFFF;
    wait_byte(100, 1, 1'b1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(400);

    // Randomized traffic.
    for (int it = 0; it < 25; it++) begin
      ch_frame_rdy = 4'($urandom);
      case ($urandom_range(0, 3))
        0: cfg_rate_step = 16'h8000;
        1: cfg_rate_step = 16'hFFFF;
        2: cfg_rate_step = 16'h3000;
        default: cfg_rate_step = 16'($urandom_range(16'h2000, 16'hFFFF));
      endcase
      cfg_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      tick($urandom_range(50, 400));
    end

    // Data counter wrap from a preloaded value.
    cfg_en = 1'b0;
    wait_idle();
    tick(2);
    force dut.data_pkt_cnt = 16'hFFFE;
    force_active = 1;
    tick(2);
    release dut.data_pkt_cnt;
    force_active = 0;
    tick(2);
    ch_frame_rdy  = 4'b1111;
    cfg_rate_step = 16'hFFFF;
    cfg_en        = 1'b1;
    tick(600);

    cfg_en = 1'b0;
    wait_idle();
    tick(10);
    done_flag = 1;
    tick(3);
  end

endmodule
